// File: rtl/multi_stage_sram_sequencer.sv
// UART capture -> NUM_STAGES decode stages -> VGA sequencer with an SRAM port mux for the current owner.
// Optional per-stage watchdog enabled by defining STAGE_WATCHDOG_EN.
module multi_stage_sram_sequencer #(
  parameter int NUM_STAGES      = 3,
  parameter int ADDR_W          = 18,
  parameter int DATA_W          = 16,
  parameter int TIMER_W         = 26,
  parameter int UART_TIMEOUT    = 49999999,
  parameter int WATCHDOG_CYCLES = 2**24
) (
  input  logic                               CLOCK_50_I,
  input  logic                               Reset,
  input  logic                               UART_RX_I,
  input  logic [ADDR_W-1:0]                  uart_addr_i,
  input  logic [DATA_W-1:0]                  uart_wdata_i,
  input  logic                               uart_we_n_i,
  input  logic [NUM_STAGES*ADDR_W-1:0]       stage_addr_i,
  input  logic [NUM_STAGES*DATA_W-1:0]       stage_wdata_i,
  input  logic [NUM_STAGES-1:0]              stage_we_n_i,
  input  logic [NUM_STAGES-1:0]              stage_end_i,
  input  logic [ADDR_W-1:0]                  vga_addr_i,
  output logic [NUM_STAGES-1:0]              stage_start_o,
  output logic                               UART_rx_initialize_o,
  output logic                               UART_rx_enable_o,
  output logic                               VGA_enable_o,
  output logic [ADDR_W-1:0]                  SRAM_address_o,
  output logic [DATA_W-1:0]                  SRAM_write_data_o,
  output logic                               SRAM_we_n_o,
  output logic [$clog2(NUM_STAGES+1)-1:0]    stage_idx_o,
  output logic                               watchdog_err_o
);

  localparam int IDX_W = $clog2(NUM_STAGES + 1);

  if (UART_TIMEOUT >= (64'd1 << TIMER_W)) begin : g_timer_too_narrow
    $error("UART_TIMEOUT does not fit in TIMER_W bits");
  end
  if (WATCHDOG_CYCLES < 1) begin : g_bad_watchdog
    $error("WATCHDOG_CYCLES must be at least 1");
  end
  if (NUM_STAGES < 1) begin : g_bad_stages
    $error("NUM_STAGES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_UART_RX,
    S_STAGE,
    S_GAP
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 init_q, init_d;
  logic                 rx_en_q, rx_en_d;
  logic                 wd_err_d;

  logic [ADDR_W-1:0]    st_addr  [NUM_STAGES];
  logic [DATA_W-1:0]    st_wdata [NUM_STAGES];

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_unpack
    assign st_addr[k]  = stage_addr_i[k*ADDR_W +: ADDR_W];
    assign st_wdata[k] = stage_wdata_i[k*DATA_W +: DATA_W];
  end

`ifdef STAGE_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_err_q;
  logic            wd_expired;

  // Counter is zero on the first cycle of every stage and counts stage cycles.
  assign wd_d       = (state_q == S_STAGE) ? wd_q + WD_W'(1) : '0;
  assign wd_expired = (wd_q == WD_W'(WATCHDOG_CYCLES - 1));

  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      wd_q     <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_q     <= wd_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign watchdog_err_o = wd_err_q;
`else
  assign watchdog_err_o = 1'b0;
`endif

  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      init_q  <= 1'b0;
      rx_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      init_q  <= init_d;
      rx_en_q <= rx_en_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    init_d   = 1'b0;
    rx_en_d  = 1'b0;
`ifdef STAGE_WATCHDOG_EN
    wd_err_d = wd_err_q;
`else
    wd_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!UART_RX_I) begin
          state_d = S_UART_RX;
          init_d  = 1'b1;
          timer_d = '0;
        end
      end
      S_UART_RX: begin
        rx_en_d = 1'b1;
        // A UART write restarts the idle window; otherwise it keeps counting.
        timer_d = uart_we_n_i ? timer_q + TIMER_W'(1) : '0;
        if (timer_q == TIMER_W'(UART_TIMEOUT)) begin
          rx_en_d = 1'b0;
          idx_d   = '0;
          timer_d = '0;
          state_d = S_STAGE;
        end
      end
      S_STAGE: begin
        if (stage_end_i[idx_q]) begin
          if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_GAP;
          end
        end
`ifdef STAGE_WATCHDOG_EN
        else if (wd_expired) begin
          wd_err_d = 1'b1;
          state_d  = S_IDLE;
        end
`endif
      end
      S_GAP: begin
        state_d = S_STAGE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    stage_start_o     = '0;
    VGA_enable_o      = 1'b0;
    SRAM_address_o    = vga_addr_i;
    SRAM_write_data_o = uart_wdata_i;
    SRAM_we_n_o       = 1'b1;
    case (state_q)
      S_IDLE: begin
        VGA_enable_o = 1'b1;
      end
      S_UART_RX: begin
        SRAM_address_o    = uart_addr_i;
        SRAM_write_data_o = uart_wdata_i;
        SRAM_we_n_o       = uart_we_n_i;
      end
      S_STAGE: begin
        stage_start_o[idx_q] = 1'b1;
        SRAM_address_o       = st_addr[idx_q];
        SRAM_write_data_o    = st_wdata[idx_q];
        SRAM_we_n_o          = stage_we_n_i[idx_q];
      end
      S_GAP: begin
        SRAM_address_o    = st_addr[idx_q];
        SRAM_write_data_o = st_wdata[idx_q];
      end
      default: begin
        VGA_enable_o = 1'b1;
      end
    endcase
  end

  assign UART_rx_initialize_o = init_q;
  assign UART_rx_enable_o     = rx_en_q;
  assign stage_idx_o          = idx_q;

endmodule

// File: tb/tb_multi_stage_sram_sequencer.sv
// Randomized frames (UART capture, staged decode, reset and hang cases) checked by a scoreboard.
module tb_multi_stage_sram_sequencer;
  localparam int NS = 3;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int TW = 26;
  localparam int TO = 100;
  localparam int WD = 50;

  logic            clk = 1'b0;
  logic            rst;
  logic            rx;
  logic [AW-1:0]   uart_addr;
  logic [DW-1:0]   uart_wdata;
  logic            uart_we_n;
  logic [NS*AW-1:0] stage_addr;
  logic [NS*DW-1:0] stage_wdata;
  logic [NS-1:0]   stage_we_n;
  logic [NS-1:0]   stage_end;
  logic [AW-1:0]   vga_addr;
  logic [NS-1:0]   stage_start_o;
  logic            UART_rx_initialize_o;
  logic            UART_rx_enable_o;
  logic            VGA_enable_o;
  logic [AW-1:0]   SRAM_address_o;
  logic [DW-1:0]   SRAM_write_data_o;
  logic            SRAM_we_n_o;
  logic [1:0]      stage_idx_o;
  logic            watchdog_err_o;

  multi_stage_sram_sequencer #(
    .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMER_W(TW),
    .UART_TIMEOUT(TO), .WATCHDOG_CYCLES(WD)
  ) dut (
    .CLOCK_50_I(clk), .Reset(rst), .UART_RX_I(rx),
    .uart_addr_i(uart_addr), .uart_wdata_i(uart_wdata), .uart_we_n_i(uart_we_n),
    .stage_addr_i(stage_addr), .stage_wdata_i(stage_wdata), .stage_we_n_i(stage_we_n),
    .stage_end_i(stage_end), .vga_addr_i(vga_addr),
    .stage_start_o(stage_start_o), .UART_rx_initialize_o(UART_rx_initialize_o),
    .UART_rx_enable_o(UART_rx_enable_o), .VGA_enable_o(VGA_enable_o),
    .SRAM_address_o(SRAM_address_o), .SRAM_write_data_o(SRAM_write_data_o),
    .SRAM_we_n_o(SRAM_we_n_o), .stage_idx_o(stage_idx_o), .watchdog_err_o(watchdog_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Control snapshot: {start[2:0], init, rx_enable, vga_enable, watchdog_err, idx[1:0]}
  typedef struct { logic [8:0] v; int c; } ctrl_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int c; } wr_t;

  ctrl_t ctrl_q[$];
  wr_t   wr_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  bit    first  = 1'b1;
  logic [8:0] prev;
  logic [1:0] m_idx;
  logic       m_err;

  function automatic logic [8:0] mk(input logic [2:0] st, input logic ini,
                                    input logic rxe, input logic vga);
    return {st, ini, rxe, vga, m_err, m_idx};
  endfunction

  task automatic push_ctrl(input int c, input logic [8:0] v);
    ctrl_t e;
    e.v = v;
    e.c = c;
    ctrl_q.push_back(e);
  endtask

  // Drives one cycle of inputs. owner: -2 nobody, -1 UART, k stage k.
  task automatic drive_cycle(input int owner, input bit own_we, input logic [NS-1:0] end_clr,
                             input logic [NS-1:0] end_set, input logic rx_v, input logic rst_v);
    wr_t w;
    rst        = rst_v;
    rx         = rx_v;
    vga_addr   = AW'($urandom);
    uart_addr  = AW'($urandom);
    uart_wdata = DW'($urandom);
    uart_we_n  = (owner == -1) ? !own_we : 1'($urandom);
    for (int k = 0; k < NS; k++) begin
      stage_addr[k*AW +: AW]  = AW'($urandom);
      stage_wdata[k*DW +: DW] = DW'($urandom);
      stage_we_n[k]           = (owner == k) ? !own_we : 1'($urandom);
    end
    stage_end = (NS'($urandom) & ~end_clr) | end_set;
    if (own_we && owner == -1) begin
      w.a = uart_addr; w.d = uart_wdata; w.c = cyc;
      wr_q.push_back(w);
    end else if (own_we && owner >= 0) begin
      w.a = stage_addr[owner*AW +: AW]; w.d = stage_wdata[owner*DW +: DW]; w.c = cyc;
      wr_q.push_back(w);
    end
    @(posedge clk);
    #1;
  endtask

  // mode 0: full frame; 1: reset during stage 1; 2: stage 1 never ends.
  task automatic run_frame(input int mode);
    int c, last, t_entry, s, e, p;
    logic [NS-1:0] own;
    repeat ($urandom_range(2, 6)) drive_cycle(-2, 0, '0, '0, 1'b1, 1'b0);
    c = cyc;
    push_ctrl(c + 1, mk(3'b000, 1'b1, 1'b0, 1'b0));
    push_ctrl(c + 2, mk(3'b000, 1'b0, 1'b1, 1'b0));
    drive_cycle(-2, 0, '0, '0, 1'b0, 1'b0);
    last = c;
    repeat ($urandom_range(2, 4)) begin
      p = $urandom_range(20, 60);
      repeat (p - 1) drive_cycle(-1, 0, '0, '0, 1'($urandom), 1'b0);
      last = cyc;
      drive_cycle(-1, 1, '0, '0, 1'($urandom), 1'b0);
    end
    // The last write is sampled at edge last+1; the idle timer then runs 0..TO before leaving.
    t_entry = last + TO + 2;
    m_idx = 2'd0;
    push_ctrl(t_entry, mk(3'b001, 1'b0, 1'b0, 1'b0));
    while (cyc < t_entry) drive_cycle(-1, 0, '0, '0, 1'($urandom), 1'b0);
    s = t_entry;
    for (int k = 0; k < NS; k++) begin
      own = NS'(1) << k;
      if (k == 1 && mode == 1) begin
        repeat ($urandom_range(3, 15)) drive_cycle(k, 1'($urandom), own, '0, 1'($urandom), 1'b0);
        m_idx = 2'd0; m_err = 1'b0;
        push_ctrl(cyc + 1, mk(3'b000, 1'b0, 1'b0, 1'b1));
        drive_cycle(k, 1, own, '0, 1'($urandom), 1'b1);
        return;
      end
      if (k == 1 && mode == 2) begin
`ifdef STAGE_WATCHDOG_EN
        m_err = 1'b1;
        push_ctrl(s + WD, mk(3'b000, 1'b0, 1'b0, 1'b1));
        while (cyc < s + WD) drive_cycle(k, 1'($urandom), own, '0, 1'($urandom), 1'b0);
`else
        repeat (200) drive_cycle(k, 1'($urandom), own, '0, 1'($urandom), 1'b0);
        m_idx = 2'd0; m_err = 1'b0;
        push_ctrl(cyc + 1, mk(3'b000, 1'b0, 1'b0, 1'b1));
        drive_cycle(k, 1'($urandom), own, '0, 1'($urandom), 1'b1);
`endif
        return;
      end
      e = s + $urandom_range(3, 30);
      while (cyc < e) drive_cycle(k, 1'($urandom), own, '0, 1'($urandom), 1'b0);
      if (k == NS - 1) begin
        push_ctrl(e + 1, mk(3'b000, 1'b0, 1'b0, 1'b1));
      end else begin
        m_idx = 2'(k + 1);
        push_ctrl(e + 1, mk(3'b000, 1'b0, 1'b0, 1'b0));
      end
      drive_cycle(k, 1'($urandom), own, own, 1'($urandom), 1'b0);
      if (k != NS - 1) begin
        push_ctrl(e + 2, mk(3'(own << 1), 1'b0, 1'b0, 1'b0));
        drive_cycle(-2, 0, '0, '0, 1'($urandom), 1'b0);
        s = e + 2;
      end
    end
  endtask

  always @(negedge clk) begin : mon
    logic [8:0] cur;
    ctrl_t ce;
    wr_t   we;
    if (mon_en) begin
      cur = {stage_start_o, UART_rx_initialize_o, UART_rx_enable_o, VGA_enable_o,
             watchdog_err_o, stage_idx_o};
      if (first || cur !== prev) begin
        checks++;
        if (ctrl_q.size() == 0) begin
          errors++;
          $display("FAIL ctrl_unexpected cycle %0d got %h required no change", cyc, cur);
        end else begin
          ce = ctrl_q.pop_front();
          if (cur !== ce.v || cyc != ce.c) begin
            errors++;
            $display("FAIL ctrl cycle %0d got %h required %h at cycle %0d", cyc, cur, ce.v, ce.c);
          end
        end
        prev  = cur;
        first = 1'b0;
      end
      if (SRAM_we_n_o !== 1'b1) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL sram_write_unexpected cycle %0d got addr %h data %h required none",
                   cyc, SRAM_address_o, SRAM_write_data_o);
        end else begin
          we = wr_q.pop_front();
          if (SRAM_we_n_o !== 1'b0 || SRAM_address_o !== we.a ||
              SRAM_write_data_o !== we.d || cyc != we.c) begin
            errors++;
            $display("FAIL sram_write cycle %0d got addr %h data %h required addr %h data %h at cycle %0d",
                     cyc, SRAM_address_o, SRAM_write_data_o, we.a, we.d, we.c);
          end
        end
      end
      if (VGA_enable_o === 1'b1) begin
        checks++;
        if (SRAM_address_o !== vga_addr) begin
          errors++;
          $display("FAIL vga_mux cycle %0d got %h required %h", cyc, SRAM_address_o, vga_addr);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rx = 1'b1;
    uart_addr = '0; uart_wdata = '0; uart_we_n = 1'b1;
    stage_addr = '0; stage_wdata = '0; stage_we_n = '1; stage_end = '0;
    vga_addr = AW'($urandom);
    m_idx = 2'd0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_ctrl(cyc, mk(3'b000, 1'b0, 1'b0, 1'b1));
    mon_en = 1'b1;
    run_frame(0);
    run_frame(0);
    run_frame(1);
    run_frame(0);
    run_frame(2);
    run_frame(0);
    repeat (5) drive_cycle(-2, 0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (ctrl_q.size() != 0) begin
      errors++;
      $display("FAIL ctrl_drain got %0d pending required 0", ctrl_q.size());
    end
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL write_drain got %0d pending required 0", wr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
